// File: rtl/ef_psram_pkg.sv
// Shared opcodes, state encoding and opcode decode for the PSRAM responder.
package ef_psram_pkg;

   localparam int CMD_BITS  = 8;
   localparam int ADDR_BITS = 24;

   localparam logic [7:0] OP_READ    = 8'h03;
   localparam logic [7:0] OP_WRITE   = 8'h02;
   localparam logic [7:0] OP_QREAD   = 8'hEB;
   localparam logic [7:0] OP_QWRITE  = 8'h38;
   localparam logic [7:0] OP_QPI_ON  = 8'h35;
   localparam logic [7:0] OP_QPI_OFF = 8'hF5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_WAIT,
      ST_RDATA,
      ST_WDATA,
      ST_IGNORE
   } state_t;

   // rw: opcode has address and data phases; quad: 4-bit address/data lanes.
   typedef struct packed {
      logic rw;
      logic read;
      logic quad;
   } op_info_t;

   function automatic op_info_t decode_op(input logic [7:0] op);
      op_info_t info;
      info = '0;
      case (op)
         OP_READ:   info = '{rw: 1'b1, read: 1'b1, quad: 1'b0};
         OP_WRITE:  info = '{rw: 1'b1, read: 1'b0, quad: 1'b0};
         OP_QREAD:  info = '{rw: 1'b1, read: 1'b1, quad: 1'b1};
         OP_QWRITE: info = '{rw: 1'b1, read: 1'b0, quad: 1'b1};
         default:   info = '0;
      endcase
      return info;
   endfunction

endpackage

// File: rtl/ef_psram_sck_sync.sv
// Synchronizes the link pins into the clk domain and produces one-clk
// rise/fall pulses of sck. ce_n and io are delayed by the same amount as the
// edge pulses so that io_s holds the value present when sck rose.
module ef_psram_sck_sync
   import ef_psram_pkg::*;
#(
   parameter int SYNC = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sck,
   input  logic       ce_n,
   input  logic [3:0] io_i,
   output logic       ce_n_s,
   output logic [3:0] io_s,
   output logic       rise,
   output logic       fall
);

   logic [SYNC-1:0] sck_ff;
   logic [SYNC-1:0] ce_ff;
   logic [3:0]      io_ff [SYNC];
   logic            sck_q;

   // Synchronizer chains plus registered edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         sck_ff <= '0;
         ce_ff  <= '1;
         for (int i = 0; i < SYNC; i++) io_ff[i] <= '0;
         sck_q  <= 1'b0;
         rise   <= 1'b0;
         fall   <= 1'b0;
         ce_n_s <= 1'b1;
         io_s   <= '0;
      end else begin
         // NOTE: non-blocking assignments make each stage take the previous
         // stage's old value, which is what turns this loop into a shift chain.
         sck_ff[0] <= sck;
         ce_ff[0]  <= ce_n;
         io_ff[0]  <= io_i;
         for (int i = 1; i < SYNC; i++) begin
            sck_ff[i] <= sck_ff[i-1];
            ce_ff[i]  <= ce_ff[i-1];
            io_ff[i]  <= io_ff[i-1];
         end
         sck_q  <= sck_ff[SYNC-1];
         rise   <= sck_ff[SYNC-1] & ~sck_q;
         fall   <= ~sck_ff[SYNC-1] & sck_q;
         ce_n_s <= ce_ff[SYNC-1];
         io_s   <= io_ff[SYNC-1];
      end
   end

endmodule

// File: rtl/ef_psram_responder.sv
// PSRAM device emulator: decodes SPI/QPI command, address, wait and data
// phases from the oversampled link and accesses a byte-wide backing SRAM.
module ef_psram_responder
   import ef_psram_pkg::*;
#(
   parameter int AW   = 23,
   parameter int SYNC = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          sck,
   input  logic          ce_n,
   input  logic [3:0]    io_i,
   output logic [3:0]    io_o,
   output logic [3:0]    io_oe,
   input  logic [3:0]    wait_cycles,
   output logic          qpi_mode,
   output logic [AW-1:0] mem_addr,
   output logic [7:0]    mem_wdata,
   output logic          mem_we,
   output logic          mem_re,
   input  logic [7:0]    mem_rdata
);

   logic          ce_n_s;
   logic [3:0]    io_s;
   logic          rise;
   logic          fall;

   state_t        state;
   state_t        state_nxt;

   logic [4:0]    bit_cnt;     // bits moved in the current phase / byte
   logic [4:0]    bit_nxt;
   logic          lane_quad;
   logic [6:0]    cmd_sr;
   logic [6:0]    wr_sr;
   logic [7:0]    rd_sr;
   logic          re_q;        // mem_rdata is valid this clk
   logic          op_read;
   logic          op_quad;     // data phase on 4 lanes
   logic          addr_quad;   // address phase on 4 lanes
   logic [3:0]    wait_n;
   logic [3:0]    wait_cnt;
   logic [AW-1:0] cur_addr;

   logic [7:0]    cmd_byte;
   logic [7:0]    wr_byte;
   logic [7:0]    rd_byte;
   logic [AW-1:0] addr_full;
   op_info_t      op_info;

   ef_psram_sck_sync #(.SYNC(SYNC)) u_sync (
      .clk    (clk),
      .rst    (rst),
      .sck    (sck),
      .ce_n   (ce_n),
      .io_i   (io_i),
      .ce_n_s (ce_n_s),
      .io_s   (io_s),
      .rise   (rise),
      .fall   (fall)
   );

   // The address shifts straight into cur_addr, so bits above AW fall off the top.
   assign cmd_byte  = qpi_mode  ? {cmd_sr[3:0], io_s} : {cmd_sr, io_s[0]};
   assign wr_byte   = op_quad   ? {wr_sr[3:0], io_s}  : {wr_sr, io_s[0]};
   assign addr_full = addr_quad ? {cur_addr[AW-5:0], io_s} : {cur_addr[AW-2:0], io_s[0]};
   assign rd_byte   = re_q ? mem_rdata : rd_sr;
   assign op_info   = decode_op(cmd_byte);

   // Lane width of the current phase and the resulting bit count after this edge.
   always_comb begin
      lane_quad = op_quad;
      case (state)
         ST_CMD:  lane_quad = qpi_mode;
         ST_ADDR: lane_quad = addr_quad;
         default: lane_quad = op_quad;
      endcase
      bit_nxt = bit_cnt + (lane_quad ? 5'd4 : 5'd1);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic; a deasserted chip enable overrides any pending edge.
   always_comb begin
      // NOTE: defaulting state_nxt before the case keeps this block free of latches.
      state_nxt = state;
      if (ce_n_s) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: state_nxt = ST_CMD;
            ST_CMD:
               if (rise && bit_nxt == 5'(CMD_BITS))
                  state_nxt = op_info.rw ? ST_ADDR : ST_IGNORE;
            ST_ADDR:
               if (rise && bit_nxt == 5'(ADDR_BITS)) begin
                  if (!op_read)         state_nxt = ST_WDATA;
                  else if (wait_n != 0) state_nxt = ST_WAIT;
                  else                  state_nxt = ST_RDATA;
               end
            ST_WAIT:
               if (rise && (wait_cnt + 4'd1) == wait_n) state_nxt = ST_RDATA;
            default: state_nxt = state;
         endcase
      end
   end

   // Datapath: shift registers, address counter, memory strobes and lane drive.
   always_ff @(posedge clk) begin
      if (rst) begin
         io_o      <= '0;
         io_oe     <= '0;
         qpi_mode  <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_we    <= 1'b0;
         mem_re    <= 1'b0;
         bit_cnt   <= '0;
         cmd_sr    <= '0;
         wr_sr     <= '0;
         rd_sr     <= '0;
         re_q      <= 1'b0;
         op_read   <= 1'b0;
         op_quad   <= 1'b0;
         addr_quad <= 1'b0;
         wait_n    <= '0;
         wait_cnt  <= '0;
         cur_addr  <= '0;
      end else begin
         mem_we <= 1'b0;
         mem_re <= 1'b0;
         re_q   <= mem_re;
         if (re_q) rd_sr <= mem_rdata;

         if (ce_n_s) begin
            io_oe   <= '0;
            io_o    <= '0;
            bit_cnt <= '0;
         end else begin
            case (state)
               ST_IDLE: bit_cnt <= '0;

               ST_CMD:
                  if (rise) begin
                     cmd_sr  <= cmd_byte[6:0];
                     bit_cnt <= bit_nxt;
                     if (bit_nxt == 5'(CMD_BITS)) begin
                        bit_cnt   <= '0;
                        wait_cnt  <= '0;
                        op_read   <= op_info.read;
                        op_quad   <= qpi_mode | op_info.quad;
                        addr_quad <= qpi_mode | op_info.quad;
                        wait_n    <= (op_info.read && op_info.quad) ? wait_cycles : 4'd0;
                        if (cmd_byte == OP_QPI_ON)  qpi_mode <= 1'b1;
                        if (cmd_byte == OP_QPI_OFF) qpi_mode <= 1'b0;
                     end
                  end

               ST_ADDR:
                  if (rise) begin
                     cur_addr <= addr_full;
                     bit_cnt  <= bit_nxt;
                     if (bit_nxt == 5'(ADDR_BITS)) begin
                        bit_cnt  <= '0;
                        mem_addr <= addr_full;
                        mem_re   <= op_read;
                     end
                  end

               ST_WAIT:
                  if (rise) wait_cnt <= wait_cnt + 4'd1;

               ST_RDATA:
                  if (fall) begin
                     io_oe <= op_quad ? 4'hF : 4'b0010;
                     if (op_quad) io_o <= (bit_cnt == 5'd0) ? rd_byte[7:4] : rd_byte[3:0];
                     else         io_o <= {2'b00, rd_byte[~bit_cnt[2:0]], 1'b0};
                     if (bit_nxt == 5'(CMD_BITS)) begin
                        // Last slice of this byte is out: prefetch the next one.
                        bit_cnt  <= '0;
                        cur_addr <= cur_addr + 1'b1;
                        mem_addr <= cur_addr + 1'b1;
                        mem_re   <= 1'b1;
                     end else begin
                        bit_cnt <= bit_nxt;
                     end
                  end

               ST_WDATA:
                  if (rise) begin
                     wr_sr <= wr_byte[6:0];
                     if (bit_nxt == 5'(CMD_BITS)) begin
                        bit_cnt   <= '0;
                        mem_wdata <= wr_byte;
                        mem_addr  <= cur_addr;
                        mem_we    <= 1'b1;
                        cur_addr  <= cur_addr + 1'b1;
                     end else begin
                        bit_cnt <= bit_nxt;
                     end
                  end

               default: ;
            endcase
         end
      end
   end

endmodule

// File: doc/ef_psram_responder.md
# ef_psram_responder

Synthesizable PSRAM device emulator: the responder end of the SPI/QSPI/QPI link that the PSRAM controller drives. It oversamples `sck`/`ce_n`/IO on the system clock, decodes command, address, wait and data phases, and reads/writes a byte-wide backing SRAM. It is used in FPGA prototypes and as the synthesizable PSRAM model in controller benches.

## Interface
Parameters:
- `AW`, default 23: backing memory address width in bytes. Address bits above `AW-1` are ignored.
- `SYNC`, default 2: synchronizer depth on `sck`, `ce_n` and `io_i`.

Ports:
- `clk`  in  1: system clock. Must run at ≥ 4× `sck`.
- `rst`  in  1: reset, synchronous, active-high.
- `sck`  in  1: link clock from the controller. Asynchronous to `clk`.
- `ce_n`  in  1: chip enable, active-low.
- `io_i`  in  4: controller `dout`.
- `io_o`  out  4: responder data to controller `din`.
- `io_oe`  out  4: per-lane output enable for `io_o`.
- `wait_cycles`  in  4: dummy `sck` cycles for quad read. Sampled at command decode.
- `qpi_mode`  out  1: current QPI state.
- `mem_addr`  out  AW: backing SRAM byte address.
- `mem_wdata`  out  8: write byte.
- `mem_we`  out  1: one-`clk` write strobe.
- `mem_re`  out  1: one-`clk` read strobe.
- `mem_rdata`  in  8: valid exactly 1 `clk` after `mem_re`.

## Operation
Edges and sampling:
- A `sck` rising edge (`rise`) is detected after synchronization.
- `io_i` is sampled on `rise`. `io_o` is updated on `fall`.
- A synchronized `ce_n` high forces IDLE from any state:
  - `io_oe=0`
  - a partially received byte is discarded (no `mem_we`)
  - `qpi_mode` keeps its value.

Bus width per phase:
- Command phase: 1-bit on `io_i[0]` (8 `rise`). When `qpi_mode=1`, 4-bit instead (2 `rise`).
- Address phase: 24 bits, MSB first.
  - 0x03/0x02 in SPI: 1-bit.
  - 0xEB/0x38, or any command in QPI: 4-bit.

Commands (opcodes live in the package):
- 0x03: serial read, 0 wait cycles. Output on `io_o[1]` with `io_oe=4'b0010`.
- 0x02: serial write. Input on `io_i[0]`.
- 0xEB: quad read, then `wait_cycles` dummies. `io_oe=4'hF` during data.
- 0x38: quad write.
- 0x35: set `qpi_mode`.
- 0xF5: clear `qpi_mode`.
- Unknown opcode: go to IGNORE until `ce_n` high. Never drive `io_oe`.

State machine:
- IDLE → CMD on `ce_n` low.
- CMD → ADDR for read/write commands.
- CMD → IGNORE after executing 0x35/0xF5, or on an unknown opcode.
- ADDR → WAIT when `wait_cycles≠0` on 0xEB.
- ADDR → RDATA or WDATA otherwise.
- WAIT → RDATA after `wait_cycles` `rise`.
- RDATA and WDATA run until `ce_n` high.

Read path:
- `mem_re` pulses on the `rise` that captures the last address bit.
- The byte is latched into the shift register 1 `clk` later.
- The first data bit is driven on the next `fall`.
- On each byte's final output `fall`, the address increments and the next byte is prefetched.

Write path:
- Each completed byte pulses `mem_we` with `mem_addr` = current address, then the address increments.

Address arithmetic:
- Increment is modulo 2^AW. Wrap from all-ones to 0 is silent.

## Timing
- Reset values: `io_o=0`, `io_oe=0`, `qpi_mode=0`, `mem_we=0`, `mem_re=0`, `mem_addr=0`, `mem_wdata=0`, state IDLE.
- Edge-detect latency: SYNC+1 `clk` from the pin to `rise`/`fall`.
- `mem_we`/`mem_re` are single-`clk` pulses, at most one per byte.
- `io_oe` asserts on the first data `fall` and deasserts on the `clk` after synchronized `ce_n` high.
- `rise` and `ce_n` deassert in the same `clk`: `ce_n` wins and the sample is dropped.
- `rst` mid-transaction: all outputs return to reset values the next `clk`. The transaction is abandoned and `qpi_mode` clears.

## Structure
- Package `ef_psram_pkg`: opcode localparams (0x03, 0x02, 0xEB, 0x38, 0x35, 0xF5), state encoding, address width constant 24.
- Sub-module `ef_psram_sck_sync`: SYNC-deep synchronizers for `sck`/`ce_n`/`io_i`, plus `rise`/`fall` pulse generation.
- Top level: FSM, bit/nibble counters, shift registers, address counter.

## Test plan
- SPI write 0x02, addr 0x000010, bytes 0xA5 0x5A → `mem_we` twice: addr 0x10=0xA5, then 0x11=0x5A.
- SPI read 0x03, addr 0x000010 → `io_o[1]` shifts 0xA5 then 0x5A MSB first; `io_oe=4'b0010`.
- 0x35, then quad write 0x38 at 0x7FFFFF, 2 bytes → writes land at 0x7FFFFF then 0x000000 (wrap, AW=23); `qpi_mode=1`.
- QPI quad read 0xEB, `wait_cycles=6`, addr 0x7FFFFF → `io_oe=0` for 6 dummy `sck` cycles, then nibbles of the two bytes just written.
- `ce_n` high after 4 bits of a write byte → no `mem_we`, state IDLE. Next 0xF5 clears `qpi_mode`.
- Opcode 0x9F → no memory access and `io_oe` stays 0 for the whole transaction.
